// File: rtl/cart_sphere_pkg.sv
// Shared widths and FSM state type for the cart_to_sphere slice.
// Rounding option is selected elsewhere by CART_TO_SPHERE_ROUND_EN.
package cart_sphere_pkg;
    localparam int COORD_W    = 16;
    localparam int SQ_W       = 32;
    localparam int ROOT_W     = 16;
    localparam int ROOT_ITERS = 16;
    localparam int CNT_W      = $clog2(ROOT_ITERS);
    localparam int REM_W      = ROOT_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        SUM,
        ROOT,
        DONE
    } state_t;
endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one result bit per cycle, MSB first.
// With CART_TO_SPHERE_ROUND_EN the final remainder is exported for rounding.
module isqrt_seq
    import cart_sphere_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SQ_W-1:0]   radicand,
    output logic              done,
    output logic [ROOT_W-1:0] root_next
`ifdef CART_TO_SPHERE_ROUND_EN
    ,
    output logic [REM_W-1:0]  rem_next
`endif
);
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic [1:0]        pair;
    logic [REM_W+1:0]  rem_sh, trial;
    logic              fits;

    // Radicand stays in place; the counter selects the next bit pair (31:30 first).
    always_comb begin
        pair   = radicand[{~cnt_q, 1'b0} +: 2];
        rem_sh = {rem_q, pair};
        trial  = {2'b00, root_q, 2'b01};
        fits   = (rem_sh >= trial);
        rem_d  = fits ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
        root_d = ROOT_W'({root_q, fits});
        done   = active_q && (cnt_q == CNT_W'(ROOT_ITERS - 1));
    end

    assign root_next = root_d;
`ifdef CART_TO_SPHERE_ROUND_EN
    assign rem_next  = rem_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_q + 1'b1;
            if (done)
                active_q <= 1'b0;
        end
    end
endmodule

// File: rtl/cart_to_sphere.sv
// Cartesian-to-spherical radius: sqrt(x^2+y^2+z^2), 19-cycle multi-cycle FSM.
// Define CART_TO_SPHERE_ROUND_EN for round-to-nearest instead of floor.
module cart_to_sphere
    import cart_sphere_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] z,
    output logic [ROOT_W-1:0]  radius,
    output logic               rdy,
    output logic               busy
);
    state_t state_q, state_d;

    logic [COORD_W-1:0]     x_q, y_q, z_q;
    logic [SQ_W-1:0]        sq_x_q, sq_y_q, sq_z_q, sum_q;
    logic signed [SQ_W-1:0] prod_x, prod_y, prod_z;
    logic                   accept, root_done;
    logic [ROOT_W-1:0]      root_next, result;
`ifdef CART_TO_SPHERE_ROUND_EN
    logic [REM_W-1:0]       rem_next;
`endif

    // DONE also accepts so back-to-back requests keep a 19-cycle period.
    assign accept = en && ((state_q == IDLE) || (state_q == DONE));
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = SQ;
            SQ:      state_d = SUM;
            SUM:     state_d = ROOT;
            ROOT:    if (root_done) state_d = DONE;
            DONE:    state_d = en ? SQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        prod_x = $signed(x_q) * $signed(x_q);
        prod_y = $signed(y_q) * $signed(y_q);
        prod_z = $signed(z_q) * $signed(z_q);
`ifdef CART_TO_SPHERE_ROUND_EN
        result = root_next + ROOT_W'(rem_next > {2'b00, root_next});
`else
        result = root_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            sq_x_q <= '0;
            sq_y_q <= '0;
            sq_z_q <= '0;
            sum_q  <= '0;
            radius <= '0;
            rdy    <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= x;
                y_q <= y;
                z_q <= z;
            end
            if (state_q == SQ) begin
                sq_x_q <= prod_x;
                sq_y_q <= prod_y;
                sq_z_q <= prod_z;
            end
            if (state_q == SUM)
                sum_q <= sq_x_q + sq_y_q + sq_z_q;
            if ((state_q == ROOT) && root_done)
                radius <= result;
            rdy <= (state_q == ROOT) && root_done;
        end
    end

    isqrt_seq u_isqrt (
        .clk       (clk),
        .rst       (rst),
        .start     (state_q == SUM),
        .radicand  (sum_q),
        .done      (root_done),
        .root_next (root_next)
`ifdef CART_TO_SPHERE_ROUND_EN
        ,
        .rem_next  (rem_next)
`endif
    );
endmodule

// File: tb/tb_cart_to_sphere.sv
// Self-checking bench for cart_to_sphere against a real-arithmetic radius model.
// Honors CART_TO_SPHERE_ROUND_EN the same way the design does.
module tb_cart_to_sphere;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] x = '0, y = '0, z = '0;
    logic [15:0] radius;
    logic        rdy, busy;

    int total = 0;
    int bad   = 0;

    cart_to_sphere dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .x      (x),
        .y      (y),
        .z      (z),
        .radius (radius),
        .rdy    (rdy),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint model_radius(input int xs, input int ys, input int zs);
        longint n, r;
        n = longint'(xs) * xs + longint'(ys) * ys + longint'(zs) * zs;
        r = longint'($floor($sqrt(real'(n))));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
`ifdef CART_TO_SPHERE_ROUND_EN
        if (n - r * r > r) r++;
`endif
        return r;
    endfunction

    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy && n < 60);
    endtask

    task automatic run_op(input logic signed [15:0] xi, input logic signed [15:0] yi,
                          input logic signed [15:0] zi, input string tag);
        int lat, busy_hi;
        bit got;
        en = 1'b1; x = xi; y = yi; z = zi;
        tick();
        en = 1'b0;
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
        busy_hi = busy ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_hi++;
            if (rdy) got = 1'b1;
        end
        chk({tag, "_latency"}, lat, 18);
        chk({tag, "_radius"}, radius, model_radius(xi, yi, zi));
        chk({tag, "_busy_cycles"}, busy_hi, 19);
        tick();
        chk({tag, "_rdy_drop"}, rdy, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, radius, model_radius(xi, yi, zi));
    endtask

    initial begin
        int n, rdy_cnt;
        logic signed [15:0] rx, ry, rz;

        // reset has priority over en
        en = 1'b1; x = 16'd3; y = 16'd4;
        tick();
        tick();
        chk("reset_radius", radius, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        en  = 1'b0;

        run_op(16'sd3, 16'sd4, 16'sd0, "r345");
        chk("r345_const", radius, 5);
        run_op(-16'sd32768, -16'sd32768, -16'sd32768, "rmax");
`ifdef CART_TO_SPHERE_ROUND_EN
        chk("rmax_const", radius, 56756);
`else
        chk("rmax_const", radius, 56755);
`endif
        run_op(16'sd1, 16'sd1, 16'sd1, "r111");
`ifdef CART_TO_SPHERE_ROUND_EN
        chk("r111_const", radius, 2);
`else
        chk("r111_const", radius, 1);
`endif
        run_op(16'sd0, 16'sd0, 16'sd0, "r000");
        chk("r000_const", radius, 0);

        // en and input changes mid-operation must be ignored
        en = 1'b1; x = 16'd3; y = 16'd4; z = 16'd0;
        tick();
        rdy_cnt = 0;
        for (int e = 1; e <= 18; e++) begin
            en = (e == 5 || e == 18);
            x  = (e == 5 || e == 18) ? 16'd100 : 16'd7;
            tick();
            if (rdy) rdy_cnt++;
        end
        chk("ign_rdy18", rdy, 1);
        chk("ign_radius", radius, 5);
        en = 1'b1; x = 16'd100; y = 16'd0; z = 16'd0;
        tick();
        chk("ign_accept19", busy, 1);
        chk("ign_rdy19", rdy, 0);
        chk("ign_single_rdy", rdy_cnt, 1);
        en = 1'b0;
        wait_rdy(n);
        chk("ign_next_lat", n, 18);
        chk("ign_next_radius", radius, model_radius(100, 0, 0));
        tick();

        // reset mid-operation
        en = 1'b1; x = 16'd3; y = 16'd4; z = 16'd0;
        tick();
        en = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_radius", radius, 0);
        chk("abort_rdy", rdy, 0);
        rst = 1'b0;
        rdy_cnt = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (rdy) rdy_cnt++;
        end
        chk("abort_no_rdy", rdy_cnt, 0);
        run_op(16'sd3, 16'sd4, 16'sd0, "after_abort");

        // back-to-back with en held high
        en = 1'b1; x = 16'd6; y = 16'd8; z = 16'd0;
        tick();
        x = 16'd0; y = 16'd0; z = 16'd7;
        wait_rdy(n);
        chk("b2b_first_lat", n, 18);
        chk("b2b_first_radius", radius, 10);
        wait_rdy(n);
        en = 1'b0;
        chk("b2b_period", n, 19);
        chk("b2b_second_radius", radius, 7);
        tick();
        chk("b2b_idle", busy, 0);

        // randomized coordinates against the model
        for (int i = 0; i < 10; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rz = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            run_op(rx, ry, rz, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
